// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The master side is the producer/consumer pair; the slave side is the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit ripple slice, LSB nibble first,
// with the inter-nibble carry held in a register.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic             co_r;
  logic [4:0]       slice;
  logic             last;

  always_comb begin
    slice = {1'b0, a_sr[3:0]} + {1'b0, b_sr[3:0]} + {4'b0000, carry};
    last  = (cnt == CW'(NIB - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.sum       = sum_sr;
    bus.co        = co_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      co_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.ci;
            cnt   <= '0;
          end
        end
        CALC: begin
          // Shift-and-OR form keeps the top-insert legal when WIDTH == 4.
          sum_sr <= (sum_sr >> 4) | (WIDTH'(slice[3:0]) << (WIDTH - 4));
          a_sr   <= a_sr >> 4;
          b_sr   <= b_sr >> 4;
          carry  <= slice[4];
          cnt    <= cnt + 1'b1;
          if (last) co_r <= slice[4];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: directed scenarios at WIDTH=16
// plus random handshake regressions at WIDTH=4, 16 and 32.
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [32:0] exp_q[$];

  nibble_serial_adder_if #(.WIDTH(4))  if4 ();
  nibble_serial_adder_if #(.WIDTH(16)) if16 ();
  nibble_serial_adder_if #(.WIDTH(32)) if32 ();

  nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  nibble_serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input int w, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic ordy);
    case (w)
      4: begin
        if4.in_valid = v; if4.a = a[3:0]; if4.b = b[3:0]; if4.ci = ci; if4.out_ready = ordy;
      end
      16: begin
        if16.in_valid = v; if16.a = a[15:0]; if16.b = b[15:0]; if16.ci = ci; if16.out_ready = ordy;
      end
      default: begin
        if32.in_valid = v; if32.a = a; if32.b = b; if32.ci = ci; if32.out_ready = ordy;
      end
    endcase
  endtask

  task automatic get_out(input int w, output logic irdy, output logic ovld, output logic [32:0] res);
    case (w)
      4: begin
        irdy = if4.in_ready; ovld = if4.out_valid; res = {28'b0, if4.co, if4.sum};
      end
      16: begin
        irdy = if16.in_ready; ovld = if16.out_valid; res = {16'b0, if16.co, if16.sum};
      end
      default: begin
        irdy = if32.in_ready; ovld = if32.out_valid; res = {if32.co, if32.sum};
      end
    endcase
  endtask

  // Reference: result bit w is the carry out, bits below are the sum.
  function automatic logic [32:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic ci);
    logic [32:0] mask;
    mask = (33'h1 << w) - 33'h1;
    return ({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'b0, ci};
  endfunction

  task automatic wait_out16(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if16.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(4, 0, '0, '0, 0, 0);
    set_in(16, 0, '0, '0, 0, 0);
    set_in(32, 0, '0, '0, 0, 0);
    repeat (3) @(negedge clk);
    total++;
    if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0)
      begin bad++; $display("FAIL reset_hold: in_ready=%b out_valid=%b want 1 0", if16.in_ready, if16.out_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (if16.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", if16.in_ready); end
    total++;
    if (if16.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", if16.out_valid); end
    total++;
    if (if16.sum !== 16'h0000) begin bad++; $display("FAIL reset_sum: got %h want 0000", if16.sum); end
    total++;
    if (if16.co !== 1'b0) begin bad++; $display("FAIL reset_co: got %b want 0", if16.co); end
    repeat (3) @(negedge clk);
    total++;
    if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0)
      begin bad++; $display("FAIL reset_idle_wait: in_ready=%b out_valid=%b want 1 0", if16.in_ready, if16.out_valid); end
  endtask

  task automatic test_basic();
    logic [32:0] got;
    logic [32:0] want;
    logic        exp_v;
    set_in(16, 1, 32'h1234, 32'h4321, 0, 1);
    exp_q.push_back(ref_add(16, 32'h1234, 32'h4321, 1'b0));
    @(negedge clk);
    set_in(16, 0, '0, '0, 0, 1);
    total++;
    if (if16.in_ready !== 1'b0) begin bad++; $display("FAIL basic_busy: in_ready=%b want 0", if16.in_ready); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_v = (k == 4);
      total++;
      if (if16.out_valid !== exp_v)
        begin bad++; $display("FAIL basic_latency k=%0d: out_valid=%b want %b", k, if16.out_valid, exp_v); end
    end
    got = {16'b0, if16.co, if16.sum};
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL basic_result: got %h want <none queued>", got); end
    else begin
      want = exp_q.pop_front();
      if (got !== want) begin bad++; $display("FAIL basic_result: got %h want %h", got, want); end
    end
    @(negedge clk);
    total++;
    if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b1)
      begin bad++; $display("FAIL basic_return_idle: out_valid=%b in_ready=%b want 0 1", if16.out_valid, if16.in_ready); end
  endtask

  task automatic test_carry();
    logic [15:0] ta [2] = '{16'hFFFF, 16'hFFFF};
    logic [15:0] tb [2] = '{16'h0000, 16'hFFFF};
    logic [16:0] tw [2] = '{17'h1_0000, 17'h1_FFFF};
    logic [32:0] got;
    logic [32:0] want;
    bit          ok;
    for (int i = 0; i < 2; i++) begin
      set_in(16, 1, {16'b0, ta[i]}, {16'b0, tb[i]}, 1, 1);
      exp_q.push_back({16'b0, tw[i]});
      @(negedge clk);
      set_in(16, 0, '0, '0, 0, 1);
      wait_out16(ok);
      got = {16'b0, if16.co, if16.sum};
      total++;
      if (!ok) begin bad++; $display("FAIL carry_timeout %0d: out_valid never rose, want 1", i); end
      else if (exp_q.size() == 0) begin bad++; $display("FAIL carry_result %0d: got %h want <none>", i, got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin bad++; $display("FAIL carry_result %0d: got %h want %h", i, got, want); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] got;
    logic [32:0] want;
    bit          ok;
    set_in(16, 1, 32'h00F0, 32'h0010, 0, 0);
    exp_q.push_back(ref_add(16, 32'h00F0, 32'h0010, 1'b0));
    @(negedge clk);
    set_in(16, 0, '0, '0, 0, 0);
    wait_out16(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_timeout: out_valid=%b want 1", if16.out_valid); end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (if16.out_valid !== 1'b1 || if16.in_ready !== 1'b0 || if16.sum !== 16'h0100 || if16.co !== 1'b0)
        begin bad++; $display("FAIL bp_hold k=%0d: ov=%b ir=%b sum=%h co=%b want 1 0 0100 0",
                              k, if16.out_valid, if16.in_ready, if16.sum, if16.co); end
      if (k == 2) set_in(16, 1, 32'h1111, 32'h2222, 1, 0);
      else        set_in(16, 0, '0, '0, 0, 0);
      @(negedge clk);
    end
    got = {16'b0, if16.co, if16.sum};
    set_in(16, 0, '0, '0, 0, 1);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL bp_result: got %h want <none>", got); end
    else begin
      want = exp_q.pop_front();
      if (got !== want) begin bad++; $display("FAIL bp_result: got %h want %h", got, want); end
    end
    @(negedge clk);
    total++;
    if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b1)
      begin bad++; $display("FAIL bp_release: ov=%b ir=%b want 0 1", if16.out_valid, if16.in_ready); end
    repeat (3) @(negedge clk);
    total++;
    if (if16.out_valid !== 1'b0)
      begin bad++; $display("FAIL bp_ignored_pulse: out_valid=%b want 0", if16.out_valid); end
  endtask

  task automatic test_mid_op();
    logic [32:0] got;
    logic [32:0] want;
    bit          ok;
    set_in(16, 1, 32'h0F0F, 32'h0101, 1, 1);
    exp_q.push_back(ref_add(16, 32'h0F0F, 32'h0101, 1'b1));
    @(negedge clk);
    set_in(16, 1, 32'hFFFF, 32'hFFFF, 1, 1);
    @(negedge clk);
    set_in(16, 1, 32'hAAAA, 32'h5555, 0, 1);
    @(negedge clk);
    set_in(16, 0, '0, '0, 0, 1);
    wait_out16(ok);
    got = {16'b0, if16.co, if16.sum};
    total++;
    if (!ok) begin bad++; $display("FAIL midop_timeout: out_valid=%b want 1", if16.out_valid); end
    else if (exp_q.size() == 0) begin bad++; $display("FAIL midop_result: got %h want <none>", got); end
    else begin
      want = exp_q.pop_front();
      if (got !== want) begin bad++; $display("FAIL midop_result: got %h want %h", got, want); end
    end
    @(negedge clk);
    set_in(16, 1, 32'h1234, 32'h1111, 0, 1);
    @(negedge clk);
    set_in(16, 0, '0, '0, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0 || if16.sum !== 16'h0000 || if16.co !== 1'b0)
      begin bad++; $display("FAIL midop_reset: ir=%b ov=%b sum=%h co=%b want 1 0 0000 0",
                            if16.in_ready, if16.out_valid, if16.sum, if16.co); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    set_in(16, 1, 32'h0001, 32'h0001, 0, 1);
    exp_q.push_back(33'h0_0002);
    @(negedge clk);
    set_in(16, 0, '0, '0, 0, 1);
    wait_out16(ok);
    got = {16'b0, if16.co, if16.sum};
    total++;
    if (!ok) begin bad++; $display("FAIL post_reset_timeout: out_valid=%b want 1", if16.out_valid); end
    else if (exp_q.size() == 0) begin bad++; $display("FAIL post_reset_result: got %h want <none>", got); end
    else begin
      want = exp_q.pop_front();
      if (got !== want) begin bad++; $display("FAIL post_reset_result: got %h want %h", got, want); end
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int w, input int ncycles);
    logic        irdy;
    logic        ovld;
    logic        v;
    logic        ordy;
    logic        c;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] got;
    logic [32:0] want;
    exp_q.delete();
    for (int i = 0; i < ncycles; i++) begin
      @(negedge clk);
      get_out(w, irdy, ovld, got);
      ordy = ($urandom_range(0, 9) < 7);
      v    = 1'($urandom_range(0, 1));
      a    = $urandom;
      b    = $urandom;
      c    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
      set_in(w, v, a, b, c, ordy);
      if (ovld && ordy) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rand_w%0d_dup: got %h want <none>", w, got); end
        else begin
          want = exp_q.pop_front();
          if (got !== want) begin bad++; $display("FAIL rand_w%0d: got %h want %h", w, got, want); end
        end
      end
      if (v && irdy) exp_q.push_back(ref_add(w, a, b, c));
    end
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      get_out(w, irdy, ovld, got);
      set_in(w, 0, '0, '0, 0, 1);
      if (ovld) begin
        total++;
        want = exp_q.pop_front();
        if (got !== want) begin bad++; $display("FAIL rand_w%0d_drain: got %h want %h", w, got, want); end
      end
    end
    @(negedge clk);
    set_in(w, 0, '0, '0, 0, 1);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rand_w%0d_lost: pending=%0d want 0", w, exp_q.size()); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_mid_op();
    test_random(16, 3000);
    test_random(4, 2000);
    test_random(32, 3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
